// File: rtl/ldpc_pkg.sv
// Shared LDPC front-end constants: default widths, code-rate selectors and
// the writer FSM state encoding.
package ldpc_pkg;

    localparam int LDPC_D_WID = 6;
    localparam int LDPC_A_WID = 8;

    localparam logic RATE_0 = 1'b0;
    localparam logic RATE_1 = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/llr_lane_pack.sv
// Collects serial LLRs into N_LANE lanes; word presents the completed word
// (including the LLR arriving this cycle) while word_rdy is high.
module llr_lane_pack
    import ldpc_pkg::*;
#(
    parameter int D_WID  = LDPC_D_WID,
    parameter int N_LANE = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      push,
    input  logic [D_WID-1:0]          din,
    output logic [N_LANE*D_WID-1:0]   word,
    output logic                      word_rdy
);

    localparam int L_WID = $clog2(N_LANE);

    logic [D_WID-1:0] lanes_q [N_LANE];
    logic [D_WID-1:0] lanes_d [N_LANE];
    logic [L_WID-1:0] lane_cnt_q;
    logic [L_WID-1:0] lane_cnt_d;

    always_comb begin
        lanes_d    = lanes_q;
        lane_cnt_d = lane_cnt_q;
        if (clr) begin
            lane_cnt_d = '0;
        end else if (push) begin
            lanes_d[lane_cnt_q] = din;
            // N_LANE is a power of two, so the wrap gives modulo N_LANE
            lane_cnt_d = lane_cnt_q + 1'b1;
        end
    end

    assign word_rdy = push && !clr && (lane_cnt_q == L_WID'(N_LANE - 1));

    always_comb begin
        word = '0;
        for (int i = 0; i < N_LANE; i++) begin
            word[i*D_WID +: D_WID] = lanes_d[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_cnt_q <= '0;
            for (int i = 0; i < N_LANE; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            lane_cnt_q <= lane_cnt_d;
            lanes_q    <= lanes_d;
        end
    end

endmodule

// File: rtl/llr_pack_writer.sv
// Packs serial LLRs into RAM words and writes whole frames into two
// ping-pong banks, stalling while the target bank is still held by the decoder.
//
// state | meaning
// IDLE  | load disabled, nothing accepted
// LOAD  | accepting LLRs into wr_bank
// WAIT  | wr_bank full, waiting for the decoder to release it
module llr_pack_writer
    import ldpc_pkg::*;
#(
    parameter int D_WID    = LDPC_D_WID,
    parameter int A_WID    = LDPC_A_WID,
    parameter int N_LANE   = 4,
    parameter int WORDS_R0 = 192,
    parameter int WORDS_R1 = 144
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_en,
    input  logic                      code_rate,
    input  logic                      sync_in,
    input  logic [D_WID-1:0]          data_in,
    input  logic                      rel_valid,
    input  logic                      rel_bank,
    output logic                      ram_wr,
    output logic                      ram_bank,
    output logic [A_WID-1:0]          ram_addr,
    output logic [N_LANE*D_WID-1:0]   ram_d,
    output logic                      frame_done,
    output logic [1:0]                bank_full,
    output logic                      ovf_err
);

    localparam logic [A_WID-1:0] LAST_R0 = A_WID'(WORDS_R0 - 1);
    localparam logic [A_WID-1:0] LAST_R1 = A_WID'(WORDS_R1 - 1);

    logic [1:0]              state_q, state_d;
    logic                    wr_bank_q, wr_bank_d;
    logic [A_WID-1:0]        word_cnt_q, word_cnt_d;
    logic                    rate_q, rate_d;
    logic                    frame_active_q, frame_active_d;
    logic                    ram_wr_q, ram_wr_d;
    logic                    ram_bank_q, ram_bank_d;
    logic [A_WID-1:0]        ram_addr_q, ram_addr_d;
    logic [N_LANE*D_WID-1:0] ram_d_q, ram_d_d;
    logic                    frame_done_q, frame_done_d;
    logic [1:0]              bank_full_q, bank_full_d;
    logic                    ovf_err_q, ovf_err_d;

    logic                    push;
    logic                    word_rdy;
    logic [N_LANE*D_WID-1:0] word;
    logic                    last_word;
    logic                    set_full;

    assign push = load_en && (state_q == ST_LOAD) && sync_in;

    llr_lane_pack #(
        .D_WID  (D_WID),
        .N_LANE (N_LANE)
    ) u_lane_pack (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (!load_en),
        .push     (push),
        .din      (data_in),
        .word     (word),
        .word_rdy (word_rdy)
    );

    // rate_q is always latched by the frame's first LLR, which precedes its first word
    assign last_word = (word_cnt_q == ((rate_q == RATE_1) ? LAST_R1 : LAST_R0));
    assign set_full  = word_rdy && last_word;

    always_comb begin
        state_d        = state_q;
        wr_bank_d      = wr_bank_q;
        word_cnt_d     = word_cnt_q;
        rate_d         = rate_q;
        frame_active_d = frame_active_q;
        ram_wr_d       = 1'b0;
        ram_bank_d     = ram_bank_q;
        ram_addr_d     = ram_addr_q;
        ram_d_d        = ram_d_q;
        frame_done_d   = 1'b0;
        bank_full_d    = bank_full_q;
        ovf_err_d      = ovf_err_q;

        if (push && !frame_active_q) begin
            rate_d         = code_rate;
            frame_active_d = 1'b1;
        end

        if (word_rdy) begin
            ram_wr_d   = 1'b1;
            ram_d_d    = word;
            ram_addr_d = word_cnt_q;
            ram_bank_d = wr_bank_q;
            if (last_word) begin
                frame_done_d   = 1'b1;
                wr_bank_d      = ~wr_bank_q;
                word_cnt_d     = '0;
                frame_active_d = 1'b0;
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end

        // set is applied after release so it wins on a same-bank collision
        if (rel_valid) begin
            bank_full_d[rel_bank] = 1'b0;
        end
        if (set_full) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    state_d = bank_full_q[wr_bank_q] ? ST_WAIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (set_full && bank_full_d[~wr_bank_q]) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sync_in) begin
                    ovf_err_d = 1'b1;
                end
                if (!bank_full_q[wr_bank_q]) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!load_en) begin
            state_d        = ST_IDLE;
            word_cnt_d     = '0;
            frame_active_d = 1'b0;
            ovf_err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            wr_bank_q      <= 1'b0;
            word_cnt_q     <= '0;
            rate_q         <= RATE_0;
            frame_active_q <= 1'b0;
            ram_wr_q       <= 1'b0;
            ram_bank_q     <= 1'b0;
            ram_addr_q     <= '0;
            ram_d_q        <= '0;
            frame_done_q   <= 1'b0;
            bank_full_q    <= 2'b00;
            ovf_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_bank_q      <= wr_bank_d;
            word_cnt_q     <= word_cnt_d;
            rate_q         <= rate_d;
            frame_active_q <= frame_active_d;
            ram_wr_q       <= ram_wr_d;
            ram_bank_q     <= ram_bank_d;
            ram_addr_q     <= ram_addr_d;
            ram_d_q        <= ram_d_d;
            frame_done_q   <= frame_done_d;
            bank_full_q    <= bank_full_d;
            ovf_err_q      <= ovf_err_d;
        end
    end

    assign ram_wr     = ram_wr_q;
    assign ram_bank   = ram_bank_q;
    assign ram_addr   = ram_addr_q;
    assign ram_d      = ram_d_q;
    assign frame_done = frame_done_q;
    assign bank_full  = bank_full_q;
    assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_llr_pack_writer.sv
// Bench for llr_pack_writer: frame table plus hand sequences for wait,
// abort, rate change, set/release collisions and mid-frame reset.
module tb_llr_pack_writer;

    localparam int D_WID  = 6;
    localparam int A_WID  = 8;
    localparam int N_LANE = 4;
    localparam int W_R0   = 4;
    localparam int W_R1   = 6;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    load_en;
    logic                    code_rate;
    logic                    sync_in;
    logic [D_WID-1:0]        data_in;
    logic                    rel_valid;
    logic                    rel_bank;
    logic                    ram_wr;
    logic                    ram_bank;
    logic [A_WID-1:0]        ram_addr;
    logic [N_LANE*D_WID-1:0] ram_d;
    logic                    frame_done;
    logic [1:0]              bank_full;
    logic                    ovf_err;

    llr_pack_writer #(
        .D_WID    (D_WID),
        .A_WID    (A_WID),
        .N_LANE   (N_LANE),
        .WORDS_R0 (W_R0),
        .WORDS_R1 (W_R1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en    (load_en),
        .code_rate  (code_rate),
        .sync_in    (sync_in),
        .data_in    (data_in),
        .rel_valid  (rel_valid),
        .rel_bank   (rel_bank),
        .ram_wr     (ram_wr),
        .ram_bank   (ram_bank),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .frame_done (frame_done),
        .bank_full  (bank_full),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                    bank;
        logic [A_WID-1:0]        addr;
        logic [N_LANE*D_WID-1:0] data;
        logic                    done;
    } wr_t;

    typedef struct {
        logic       rate;
        int         base;
        logic       bank;
        logic [1:0] full;
        logic [1:0] st;
    } row_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N_LANE*D_WID-1:0] pack_word(input int first);
        logic [N_LANE*D_WID-1:0] w;
        w = '0;
        for (int j = 0; j < N_LANE; j++) begin
            w[j*D_WID +: D_WID] = D_WID'((first + j) & 63);
        end
        return w;
    endfunction

    // Scoreboard: every write the DUT makes must match the head of exp_q
    always @(negedge clk) begin
        if (reset_n && ram_wr) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wr: got write bank %0d addr %0d, expected none", ram_bank, ram_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_bank", 32'(ram_bank), 32'(e.bank));
                check("wr_addr", 32'(ram_addr), 32'(e.addr));
                check("wr_data", 32'(ram_d), 32'(e.data));
                check("wr_done", 32'(frame_done), 32'(e.done));
            end
        end else if (reset_n && frame_done) begin
            check("done_without_wr", 32'(ram_wr), 32'd1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_llrs(input int n, input int base, input int flip_after,
                              input logic rel_last, input logic rel_b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == flip_after) code_rate = ~code_rate;
            sync_in = 1'b1;
            data_in = D_WID'((base + i) & 63);
            if (rel_last && i == n - 1) begin
                rel_valid = 1'b1;
                rel_bank  = rel_b;
            end
        end
        @(negedge clk);
        sync_in   = 1'b0;
        rel_valid = 1'b0;
    endtask

    task automatic expect_words(input int nwords, input int base, input logic bank,
                                input logic is_frame);
        for (int w = 0; w < nwords; w++) begin
            wr_t e;
            e.bank = bank;
            e.addr = A_WID'(w);
            e.data = pack_word(base + N_LANE * w);
            e.done = is_frame && (w == nwords - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic release_bank(input logic b);
        @(negedge clk);
        rel_valid = 1'b1;
        rel_bank  = b;
        @(negedge clk);
        rel_valid = 1'b0;
        cycles(1);
    endtask

    row_t rows[2];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rows[0] = '{rate: 1'b0, base: 1,  bank: 1'b0, full: 2'b01, st: 2'd1};
        rows[1] = '{rate: 1'b1, base: 17, bank: 1'b1, full: 2'b11, st: 2'd2};

        reset_n = 1'b0; load_en = 1'b0; code_rate = 1'b0; sync_in = 1'b0;
        data_in = '0;   rel_valid = 1'b0; rel_bank = 1'b0;
        #12;
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_d", 32'(ram_d), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_bank", 32'(ram_bank), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_bank_full", 32'(bank_full), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        load_en = 1'b1;
        cycles(2);

        // Table: back-to-back frames into alternating banks
        for (int r = 0; r < 2; r++) begin
            int nw;
            nw = rows[r].rate ? W_R1 : W_R0;
            code_rate = rows[r].rate;
            expect_words(nw, rows[r].base, rows[r].bank, 1'b1);
            drive_llrs(nw * N_LANE, rows[r].base, -1, 1'b0, 1'b0);
            drain("row_drain");
            check("row_bank_full", 32'(bank_full), 32'(rows[r].full));
            check("row_state", 32'(dut.state_q), 32'(rows[r].st));
        end

        // WAIT: LLRs dropped and flagged, release of bank 0 resumes loading
        drive_llrs(3, 50, -1, 1'b0, 1'b0);
        cycles(3);
        check("wait_ovf", 32'(ovf_err), 32'd1);
        release_bank(1'b0);
        check("rel_state", 32'(dut.state_q), 32'd1);
        check("rel_full", 32'(bank_full), 32'b10);
        code_rate = 1'b1;
        expect_words(W_R1, 41, 1'b0, 1'b1);
        drive_llrs(W_R1 * N_LANE, 41, -1, 1'b0, 1'b0);
        drain("f3_drain");
        check("f3_full", 32'(bank_full), 32'b11);
        check("f3_state", 32'(dut.state_q), 32'd2);
        check("ovf_sticky", 32'(ovf_err), 32'd1);

        // Abort after 6 LLRs, then a full frame restarts at address 0
        release_bank(1'b1);
        code_rate = 1'b0;
        expect_words(1, 30, 1'b1, 1'b0);
        drive_llrs(6, 30, -1, 1'b0, 1'b0);
        drain("abort_drain");
        load_en = 1'b0;
        cycles(2);
        check("abort_ovf_clr", 32'(ovf_err), 32'd0);
        check("abort_state", 32'(dut.state_q), 32'd0);
        check("abort_full_kept", 32'(bank_full), 32'b01);
        load_en = 1'b1;
        cycles(2);
        expect_words(W_R0, 1, 1'b1, 1'b1);
        drive_llrs(W_R0 * N_LANE, 1, -1, 1'b0, 1'b0);
        drain("restart_drain");
        check("restart_full", 32'(bank_full), 32'b11);

        // Mid-frame rate change ignored; release of bank 1 coincides with set of bank 0
        release_bank(1'b0);
        code_rate = 1'b0;
        expect_words(W_R0, 10, 1'b0, 1'b1);
        drive_llrs(W_R0 * N_LANE, 10, 5, 1'b1, 1'b1);
        drain("rate_drain");
        check("set_rel_full", 32'(bank_full), 32'b01);
        check("set_rel_state", 32'(dut.state_q), 32'd1);

        // Set and release of the same bank in one cycle: set wins
        code_rate = 1'b0;
        expect_words(W_R0, 20, 1'b1, 1'b1);
        drive_llrs(W_R0 * N_LANE, 20, -1, 1'b1, 1'b1);
        drain("same_drain");
        check("same_bank_full", 32'(bank_full), 32'b11);
        check("same_bank_state", 32'(dut.state_q), 32'd2);

        // Asynchronous reset mid-frame
        release_bank(1'b0);
        expect_words(1, 5, 1'b0, 1'b0);
        drive_llrs(7, 5, -1, 1'b0, 1'b0);
        drain("prerst_drain");
        @(negedge clk);
        sync_in = 1'b1;
        data_in = 6'd33;
        #1;
        reset_n = 1'b0;
        #1;
        check("mrst_ram_wr", 32'(ram_wr), 32'd0);
        check("mrst_ram_d", 32'(ram_d), 32'd0);
        check("mrst_ram_addr", 32'(ram_addr), 32'd0);
        check("mrst_ram_bank", 32'(ram_bank), 32'd0);
        check("mrst_frame_done", 32'(frame_done), 32'd0);
        check("mrst_bank_full", 32'(bank_full), 32'd0);
        check("mrst_ovf_err", 32'(ovf_err), 32'd0);
        check("mrst_state", 32'(dut.state_q), 32'd0);
        sync_in = 1'b0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
